// File: rtl/ciphertext_serializer.sv
// Serializes one 128-bit AES ciphertext block into 16 byte writes, MSB first,
// addressed by the external ciphertext pointer. Optional parity: CT_SER_PARITY_EN.
module ciphertext_serializer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ct_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [ADDR_W-1:0] ptr_pc,
  output logic              ptr_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              block_done,
  output logic              wrap_flag,
  output logic              busy,
`ifdef CT_SER_PARITY_EN
  output logic              mem_wparity,
  output logic              par_err,
`endif
  output logic              dbg_state
);

  // Handshake: a block transfers on a rising edge where ct_valid && ct_ready.
  // ct_ready is high only in IDLE, so a block is never accepted mid-serialization.

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              wrap_q, wrap_d;
  logic              last_byte;

`ifdef CT_SER_PARITY_EN
  logic blk_par_q, blk_par_d;
  logic acc_par_q, acc_par_d;
  logic par_err_q, par_err_d;
  logic byte_par;
`endif

  assign last_byte = (byte_cnt_q == CNT_W'(NBYTES - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      wrap_q     <= 1'b0;
`ifdef CT_SER_PARITY_EN
      blk_par_q  <= 1'b0;
      acc_par_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      wrap_q     <= wrap_d;
`ifdef CT_SER_PARITY_EN
      blk_par_q  <= blk_par_d;
      acc_par_q  <= acc_par_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    // Sticky: any write landing on the top address marks a pointer wrap.
    wrap_d     = wrap_q | (mem_we & (&ptr_pc));
`ifdef CT_SER_PARITY_EN
    blk_par_d  = blk_par_q;
    acc_par_d  = acc_par_q;
    par_err_d  = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (ct_valid) begin
          state_d    = SHIFT;
          shreg_d    = ct_data;
          byte_cnt_d = '0;
`ifdef CT_SER_PARITY_EN
          blk_par_d  = ^ct_data;
          acc_par_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        shreg_d    = {shreg_q[DATA_W-9:0], 8'h00};
        byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef CT_SER_PARITY_EN
        acc_par_d  = acc_par_q ^ byte_par;
        if (last_byte) begin
          par_err_d = par_err_q | (blk_par_q != (acc_par_q ^ byte_par));
        end
`endif
        if (last_byte) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ct_ready   = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    ptr_enable = 1'b0;
    block_done = 1'b0;
    case (state_q)
      IDLE: begin
        ct_ready = 1'b1;
      end
      SHIFT: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        ptr_enable = 1'b1;
        block_done = last_byte;
      end
      default: ct_ready = 1'b0;
    endcase
  end

  assign mem_addr  = ptr_pc;
  assign mem_wdata = shreg_q[DATA_W-1 -: 8];
  assign wrap_flag = wrap_q;
  assign dbg_state = (state_q == SHIFT);

`ifdef CT_SER_PARITY_EN
  assign byte_par    = ^mem_wdata;
  assign mem_wparity = mem_we & byte_par;
  assign par_err     = par_err_q;
`endif

endmodule
